// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared definitions for the branch/jump redirect controller.
// Holds default widths, the register-index type, the x0 constant,
// the two FSM state encodings and a PC alignment helper.
package branch_redirect_ctrl_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int CNT_W_DEF = 32;
    localparam int REG_W     = 5;

    typedef logic [REG_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_X0 = '0;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    // Instructions are 4-byte aligned; any set low bit is a misaligned target.
    function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// Pipeline-side bundle for branch_redirect_ctrl.
// slave  : the controller (receives EX/ID/IF status, drives PC select,
//          stalls, flushes, misalign pulse and performance counters).
// master : the pipeline / testbench side.
interface branch_redirect_ctrl_if
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             ex_valid;
    logic             ex_is_branch;
    logic             ex_is_jal;
    logic             ex_is_jalr;
    logic             ex_cmp_res;
    logic [XLEN-1:0]  ex_target;
    logic             ex_mem_read;
    logic             ex_rd_wen;
    reg_idx_t         ex_rd;
    reg_idx_t         id_rs1;
    reg_idx_t         id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             if_ready;
    logic             mem_busy;

    logic             pc_sel;
    logic [XLEN-1:0]  redirect_pc;
    logic             stall_if;
    logic             stall_id;
    logic             flush_id;
    logic             flush_ex;
    logic             misalign;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] redir_cnt;

    modport slave (
        input  ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_cmp_res,
               ex_target, ex_mem_read, ex_rd_wen, ex_rd,
               id_rs1, id_rs2, id_use_rs1, id_use_rs2, if_ready, mem_busy,
        output pc_sel, redirect_pc, stall_if, stall_id, flush_id, flush_ex,
               misalign, br_cnt, redir_cnt
    );

    modport master (
        output ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_cmp_res,
               ex_target, ex_mem_read, ex_rd_wen, ex_rd,
               id_rs1, id_rs2, id_use_rs1, id_use_rs2, if_ready, mem_busy,
        input  pc_sel, redirect_pc, stall_if, stall_id, flush_id, flush_ex,
               misalign, br_cnt, redir_cnt
    );

endinterface

// File: rtl/branch_redirect_ctrl_hazard_detect.sv
// Load-use hazard detection (purely combinational).
// Ports: ex_mem_read_i, ex_rd_wen_i, ex_rd_i  - load in EX and its destination
//        id_rs1_i/id_rs2_i, id_use_rs1_i/id_use_rs2_i - ID source operands
//        ldu_o - ID instruction needs the load result that is not yet available
module branch_redirect_ctrl_hazard_detect
    import branch_redirect_ctrl_pkg::*;
(
    input  logic     ex_mem_read_i,
    input  logic     ex_rd_wen_i,
    input  reg_idx_t ex_rd_i,
    input  reg_idx_t id_rs1_i,
    input  reg_idx_t id_rs2_i,
    input  logic     id_use_rs1_i,
    input  logic     id_use_rs2_i,
    output logic     ldu_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_use_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit = id_use_rs2_i && (id_rs2_i == ex_rd_i);

    // A load into x0 never produces a value anyone waits on.
    assign ldu_o = ex_mem_read_i && ex_rd_wen_i && (ex_rd_i != REG_X0)
                   && (rs1_hit || rs2_hit);

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch/jump redirect and load-use hazard control for the 5-stage pipeline.
// Ports: clk, rst (sync, active-high), bus (branch_redirect_ctrl_if.slave).
// Resolves the EX taken decision, selects the redirect PC with zero cycle
// latency, holds the redirect while fetch is not ready, inserts load-use
// bubbles and counts resolved branches and taken redirects.
//
// state | meaning
// IDLE  | normal flow; redirect/bubble decided directly from EX/ID inputs
// PEND  | redirect issued but fetch not ready; keep driving pend_pc_q
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_redirect_ctrl_if.slave bus
);

    logic [0:0]       state_q, state_d;
    logic [XLEN-1:0]  pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

    logic take;
    logic ldu;

    logic            pc_sel;
    logic [XLEN-1:0] redirect_pc;
    logic            stall_if;
    logic            stall_id;
    logic            flush_id;
    logic            flush_ex;
    logic            misalign;

    assign take = bus.ex_valid
                  && ((bus.ex_is_branch && bus.ex_cmp_res) || bus.ex_is_jal || bus.ex_is_jalr);

    branch_redirect_ctrl_hazard_detect u_hazard_detect (
        .ex_mem_read_i (bus.ex_mem_read),
        .ex_rd_wen_i   (bus.ex_rd_wen),
        .ex_rd_i       (bus.ex_rd),
        .id_rs1_i      (bus.id_rs1),
        .id_rs2_i      (bus.id_rs2),
        .id_use_rs1_i  (bus.id_use_rs1),
        .id_use_rs2_i  (bus.id_use_rs2),
        .ldu_o         (ldu)
    );

    always_comb begin
        pc_sel      = 1'b0;
        redirect_pc = (state_q == ST_PEND) ? pend_pc_q : bus.ex_target;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        flush_id    = 1'b0;
        flush_ex    = 1'b0;
        misalign    = 1'b0;
        if (rst) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else if (bus.mem_busy) begin
            // Whole pipe frozen; a pending redirect keeps its PC select.
            stall_if = 1'b1;
            stall_id = 1'b1;
            pc_sel   = (state_q == ST_PEND);
        end else if (take) begin
            // Take beats a load-use hit: the ID instruction is wrong-path.
            pc_sel      = 1'b1;
            redirect_pc = bus.ex_target;
            flush_id    = 1'b1;
            flush_ex    = (state_q == ST_IDLE);
            misalign    = pc_misaligned(bus.ex_target[1:0]);
        end else if (state_q == ST_PEND) begin
            pc_sel   = 1'b1;
            flush_id = 1'b1;
        end else if (ldu) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_pc_d   = pend_pc_q;
        br_cnt_d    = br_cnt_q;
        redir_cnt_d = redir_cnt_q;
        if (!bus.mem_busy) begin
            if (bus.ex_valid && bus.ex_is_branch) begin
                br_cnt_d = br_cnt_q + CNT_W'(1);
            end
            if (take) begin
                redir_cnt_d = redir_cnt_q + CNT_W'(1);
                if (bus.if_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_PEND;
                    pend_pc_d = bus.ex_target;
                end
            end else if ((state_q == ST_PEND) && bus.if_ready) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pend_pc_q   <= '0;
            br_cnt_q    <= '0;
            redir_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_pc_q   <= pend_pc_d;
            br_cnt_q    <= br_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign bus.pc_sel      = pc_sel;
    assign bus.redirect_pc = redirect_pc;
    assign bus.stall_if    = stall_if;
    assign bus.stall_id    = stall_id;
    assign bus.flush_id    = flush_id;
    assign bus.flush_ex    = flush_ex;
    assign bus.misalign    = misalign;
    assign bus.br_cnt      = br_cnt_q;
    assign bus.redir_cnt   = redir_cnt_q;

endmodule
